// File: rtl/csr_counter_file.sv
// Machine/user counter CSRs with a scratch array, privilege and counter-enable checks,
// per-counter inhibit, multi-retire instret and sticky overflow interrupt.
module csr_counter_file #(
    parameter int XLEN          = 64,
    parameter int NUM_HPM       = 4,
    parameter int RETIRE_W      = 3,
    parameter int SCRATCH_DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_valid_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [1:0]          csr_op_i,
    input  logic [XLEN-1:0]     csr_wdata_i,
    input  logic [1:0]          csr_priv_i,
    output logic                csr_rvalid_o,
    output logic [XLEN-1:0]     csr_rdata_o,
    output logic                csr_illegal_o,
    input  logic [RETIRE_W-1:0] instret_inc_i,
    input  logic [NUM_HPM-1:0]  hpm_event_i,
    output logic                ovf_irq_o
);

    localparam int NCNT = 3 + NUM_HPM;
    localparam int SW   = (SCRATCH_DEPTH > 1) ? $clog2(SCRATCH_DEPTH) : 1;
    // Implemented bits of mcounteren/mcountinhibit: 0 and 2..2+NUM_HPM; bit 1 (time) is absent.
    localparam logic [XLEN-1:0] CTRL_MASK = {{(XLEN-NCNT){1'b0}}, {(NCNT-2){1'b1}}, 2'b01};

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic [XLEN-1:0] scratch_r [SCRATCH_DEPTH];
    logic [XLEN-1:0] cnt_r [NCNT];
    logic [NCNT-1:0] ovf_r;
    logic [XLEN-1:0] counteren_r;
    logic [XLEN-1:0] inhibit_r;
    logic            rvalid_r;
    logic [XLEN-1:0] rdata_r;
    logic            illegal_r;
    logic            irq_r;

    logic [4:0]      cidx_s;
    logic [SW-1:0]   sidx_s;
    logic            cnt_hit_s;
    logic            is_scratch_s;
    logic            is_cen_s;
    logic            is_inh_s;
    logic            is_mcnt_s;
    logic            is_ucnt_s;
    logic            mapped_s;
    logic            priv_m_s;
    logic            cen_bit_s;
    logic [XLEN-1:0] cnt_old_s;
    logic [XLEN-1:0] old_s;
    logic [XLEN-1:0] new_s;
    logic            wr_req_s;
    logic            illegal_s;
    logic            do_write_s;

    logic [XLEN-1:0] inc_s [NCNT];
    logic [XLEN-1:0] sum_s [NCNT];
    logic [NCNT-1:0] carry_s;
    logic [NCNT-1:0] cnt_wr_s;

    assign cidx_s = csr_addr_i[4:0];
    assign sidx_s = csr_addr_i[SW-1:0];

    // Address decode, legality check and read-modify-write value.
    always_comb begin
        cnt_old_s = '0;
        cen_bit_s = 1'b0;
        for (int k = 0; k < NCNT; k++) begin
            cnt_old_s = (cidx_s == 5'(k)) ? cnt_r[k] : cnt_old_s;
            cen_bit_s = (cidx_s == 5'(k)) ? counteren_r[k] : cen_bit_s;
        end
        cnt_hit_s    = (cidx_s == 5'd0) || (cidx_s == 5'd2) ||
                       ((cidx_s >= 5'd3) && ({27'd0, cidx_s} < 32'(NCNT)));
        is_scratch_s = ({20'd0, csr_addr_i} < 32'(SCRATCH_DEPTH));
        is_cen_s     = (csr_addr_i == 12'h306);
        is_inh_s     = (csr_addr_i == 12'h320);
        is_mcnt_s    = (csr_addr_i[11:5] == 7'h58) && cnt_hit_s;
        is_ucnt_s    = (csr_addr_i[11:5] == 7'h60) && cnt_hit_s;
        mapped_s     = is_scratch_s || is_cen_s || is_inh_s || is_mcnt_s || is_ucnt_s;
        priv_m_s     = (csr_priv_i == 2'd3);

        if (is_scratch_s) begin
            old_s = scratch_r[sidx_s];
        end else if (is_cen_s) begin
            old_s = counteren_r;
        end else if (is_inh_s) begin
            old_s = inhibit_r;
        end else if (is_mcnt_s || is_ucnt_s) begin
            old_s = cnt_old_s;
        end else begin
            old_s = '0;
        end

        case (csr_op_i)
            OP_RW:        wr_req_s = 1'b1;
            OP_RS, OP_RC: wr_req_s = |csr_wdata_i;
            default:      wr_req_s = 1'b0;
        endcase

        case (csr_op_i)
            OP_RS:   new_s = old_s | csr_wdata_i;
            OP_RC:   new_s = old_s & ~csr_wdata_i;
            default: new_s = csr_wdata_i;
        endcase

        illegal_s  = !mapped_s ||
                     (!priv_m_s && (is_cen_s || is_inh_s || is_mcnt_s)) ||
                     (is_ucnt_s && !priv_m_s && !cen_bit_s) ||
                     (is_ucnt_s && wr_req_s);
        do_write_s = csr_valid_i && !illegal_s && wr_req_s && (csr_op_i != OP_READ);
    end

    // Per-counter increment amount, wrapped sum with carry-out, and software-write hit.
    always_comb begin
        for (int k = 0; k < NCNT; k++) begin
            inc_s[k] = '0;
        end
        inc_s[0] = {{(XLEN-1){1'b0}}, 1'b1};
        inc_s[2] = XLEN'(instret_inc_i);
        for (int i = 0; i < NUM_HPM; i++) begin
            inc_s[3+i] = {{(XLEN-1){1'b0}}, hpm_event_i[i]};
        end
        for (int k = 0; k < NCNT; k++) begin
            {carry_s[k], sum_s[k]} = {1'b0, cnt_r[k]} + {1'b0, inc_s[k]};
            cnt_wr_s[k] = do_write_s && is_mcnt_s && (cidx_s == 5'(k));
        end
    end

    // Architectural state: scratch, control CSRs, counters and overflow flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SCRATCH_DEPTH; i++) begin
                scratch_r[i] <= '0;
            end
            for (int k = 0; k < NCNT; k++) begin
                cnt_r[k] <= '0;
            end
            ovf_r       <= '0;
            counteren_r <= '0;
            inhibit_r   <= '0;
        end else begin
            if (do_write_s && is_scratch_s) begin
                scratch_r[sidx_s] <= new_s;
            end
            if (do_write_s && is_cen_s) begin
                counteren_r <= new_s & CTRL_MASK;
            end
            if (do_write_s && is_inh_s) begin
                inhibit_r <= new_s & CTRL_MASK;
            end
            // A software write beats the increment and clears a same-cycle overflow.
            for (int k = 0; k < NCNT; k++) begin
                if (cnt_wr_s[k]) begin
                    cnt_r[k] <= new_s;
                    ovf_r[k] <= 1'b0;
                end else if (!inhibit_r[k]) begin
                    cnt_r[k] <= sum_s[k];
                    if (carry_s[k]) begin
                        ovf_r[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Registered response and interrupt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            illegal_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            rvalid_r  <= csr_valid_i;
            illegal_r <= csr_valid_i && illegal_s;
            if (csr_valid_i) begin
                rdata_r <= illegal_s ? '0 : old_s;
            end
            irq_r <= |ovf_r;
        end
    end

    assign csr_rvalid_o  = rvalid_r;
    assign csr_rdata_o   = rdata_r;
    assign csr_illegal_o = illegal_r;
    assign ovf_irq_o     = irq_r;

endmodule

// File: tb/tb_csr_counter_file.sv
// Directed bench for csr_counter_file: a behavioural CSR model is checked against the
// DUT every cycle, and key results are also pinned to hand-computed literals.
module tb_csr_counter_file;

    localparam int XLEN     = 64;
    localparam int NUM_HPM  = 4;
    localparam int RETIRE_W = 3;
    localparam int DEPTH    = 32;
    localparam longint unsigned MASK = 64'h7D;

    logic                clk;
    logic                rst_n;
    logic                csr_valid_i;
    logic [11:0]         csr_addr_i;
    logic [1:0]          csr_op_i;
    logic [XLEN-1:0]     csr_wdata_i;
    logic [1:0]          csr_priv_i;
    logic                csr_rvalid_o;
    logic [XLEN-1:0]     csr_rdata_o;
    logic                csr_illegal_o;
    logic [RETIRE_W-1:0] instret_inc_i;
    logic [NUM_HPM-1:0]  hpm_event_i;
    logic                ovf_irq_o;

    csr_counter_file #(
        .XLEN(XLEN), .NUM_HPM(NUM_HPM), .RETIRE_W(RETIRE_W), .SCRATCH_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .csr_valid_i(csr_valid_i), .csr_addr_i(csr_addr_i),
        .csr_op_i(csr_op_i), .csr_wdata_i(csr_wdata_i), .csr_priv_i(csr_priv_i),
        .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .instret_inc_i(instret_inc_i), .hpm_event_i(hpm_event_i), .ovf_irq_o(ovf_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint unsigned m_scr [DEPTH];
    longint unsigned m_cnt [32];
    bit              m_ovf [32];
    longint unsigned m_en, m_inh;
    bit              e_rvalid, e_illegal, e_irq;
    longint unsigned e_rdata;
    int              n_checks = 0;
    int              n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per clock edge, using the inputs held across that edge.
    task automatic model_edge();
        int a, cidx, wr_cidx, wr_kind, sidx;
        bit mapped, monly, ro, user, wr, ill, any_ovf;
        longint unsigned old, nv, inc, inh_old, wd;
        any_ovf = 1'b0;
        for (int k = 0; k < 32; k++) any_ovf |= m_ovf[k];
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_scr[i] = 0;
            for (int k = 0; k < 32; k++) begin m_cnt[k] = 0; m_ovf[k] = 1'b0; end
            m_en = 0; m_inh = 0;
            e_rvalid = 1'b0; e_rdata = 0; e_illegal = 1'b0; e_irq = 1'b0;
            return;
        end
        wr_cidx = -1; wr_kind = 0; sidx = 0; nv = 0; cidx = 0;
        e_rvalid = csr_valid_i;
        if (csr_valid_i) begin
            a = int'(csr_addr_i); wd = csr_wdata_i;
            mapped = 1'b0; monly = 1'b0; ro = 1'b0; old = 0;
            if (a < DEPTH) begin mapped = 1'b1; sidx = a; old = m_scr[a]; end
            else if (a == 'h306) begin mapped = 1'b1; monly = 1'b1; old = m_en; end
            else if (a == 'h320) begin mapped = 1'b1; monly = 1'b1; old = m_inh; end
            else if (a >= 'hB00 && a < 'hB03 + NUM_HPM && a != 'hB01) begin
                mapped = 1'b1; monly = 1'b1; cidx = a - 'hB00; old = m_cnt[cidx];
            end else if (a >= 'hC00 && a < 'hC03 + NUM_HPM && a != 'hC01) begin
                mapped = 1'b1; ro = 1'b1; cidx = a - 'hC00; old = m_cnt[cidx];
            end
            user = (csr_priv_i != 2'd3);
            wr   = (csr_op_i == 2'b01) || (csr_op_i[1] && wd != 0);
            ill  = !mapped || (user && monly) || (ro && user && !m_en[cidx]) || (ro && wr);
            e_rdata   = ill ? 0 : old;
            e_illegal = ill;
            case (csr_op_i)
                2'b10:   nv = old | wd;
                2'b11:   nv = old & ~wd;
                default: nv = wd;
            endcase
            if (!ill && wr) begin
                if (a < DEPTH) wr_kind = 1;
                else if (a == 'h306) wr_kind = 2;
                else if (a == 'h320) wr_kind = 3;
                else begin wr_kind = 4; wr_cidx = cidx; end
            end
        end
        inh_old = m_inh;
        for (int k = 0; k < 3 + NUM_HPM; k++) begin
            if (k != 1 && k != wr_cidx && !inh_old[k]) begin
                inc = (k == 0) ? 1 : (k == 2) ? longint'(instret_inc_i) : longint'(hpm_event_i[k-3]);
                if (inc != 0 && m_cnt[k] + inc < m_cnt[k]) m_ovf[k] = 1'b1;
                m_cnt[k] = m_cnt[k] + inc;
            end
        end
        case (wr_kind)
            1: m_scr[sidx] = nv;
            2: m_en = nv & MASK;
            3: m_inh = nv & MASK;
            4: begin m_cnt[wr_cidx] = nv; m_ovf[wr_cidx] = 1'b0; end
            default: ;
        endcase
        e_irq = any_ovf;
    endtask

    task automatic compare();
        chk("rvalid", 64'(csr_rvalid_o), 64'(e_rvalid));
        chk("rdata", csr_rdata_o, e_rdata);
        if (e_rvalid) chk("illegal", 64'(csr_illegal_o), 64'(e_illegal));
        chk("ovf_irq", 64'(ovf_irq_o), 64'(e_irq));
    endtask

    task automatic step(input logic v, input logic [11:0] a, input logic [1:0] op,
                        input logic [63:0] wd, input logic [1:0] pr);
        csr_valid_i = v; csr_addr_i = a; csr_op_i = op; csr_wdata_i = wd; csr_priv_i = pr;
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 12'h000, 2'b00, 64'd0, 2'd3);
    endtask

    initial begin
        rst_n = 1'b0; instret_inc_i = '0; hpm_event_i = '0;
        csr_valid_i = 1'b0; csr_addr_i = '0; csr_op_i = '0; csr_wdata_i = '0; csr_priv_i = 2'd3;
        repeat (3) idle();
        chk("reset_rdata", csr_rdata_o, 64'd0);
        rst_n = 1'b1;

        // Test 1: mcycle read after four counting cycles
        repeat (4) idle();
        step(1'b1, 12'hB00, 2'b00, 64'd0, 2'd3);
        chk("t1_mcycle", csr_rdata_o, 64'd4);
        chk("t1_illegal", 64'(csr_illegal_o), 64'd0);

        // Test 2: scratch RW / RS / RC
        step(1'b1, 12'h005, 2'b01, 64'hA5, 2'd3);
        chk("t2_rw_old", csr_rdata_o, 64'd0);
        step(1'b1, 12'h005, 2'b10, 64'h0F00, 2'd3);
        chk("t2_rs_old", csr_rdata_o, 64'hA5);
        step(1'b1, 12'h005, 2'b11, 64'h05, 2'd3);
        chk("t2_rc_old", csr_rdata_o, 64'hFA5);
        step(1'b1, 12'h005, 2'b00, 64'd0, 2'd0);
        chk("t2_final", csr_rdata_o, 64'hFA0);

        // Test 3: privilege and counter-enable
        step(1'b1, 12'hC02, 2'b00, 64'd0, 2'd0);
        chk("t3_u_ill", 64'(csr_illegal_o), 64'd1);
        step(1'b1, 12'h306, 2'b01, 64'h4, 2'd3);
        step(1'b1, 12'hC02, 2'b00, 64'd0, 2'd1);
        chk("t3_u_ok", 64'(csr_illegal_o), 64'd0);
        chk("t3_instret", csr_rdata_o, 64'd0);
        step(1'b1, 12'h320, 2'b01, 64'hFF, 2'd0);
        chk("t3_inh_ill", 64'(csr_illegal_o), 64'd1);
        step(1'b1, 12'h320, 2'b00, 64'd0, 2'd3);
        chk("t3_inh_keep", csr_rdata_o, 64'd0);
        step(1'b1, 12'hC00, 2'b01, 64'd1, 2'd3);
        chk("t3_c_write_ill", 64'(csr_illegal_o), 64'd1);
        step(1'b1, 12'hC00, 2'b10, 64'd0, 2'd3);
        chk("t3_c_rs0_ok", 64'(csr_illegal_o), 64'd0);
        step(1'b1, 12'hB01, 2'b00, 64'd0, 2'd3);
        chk("t3_b01_ill", 64'(csr_illegal_o), 64'd1);
        step(1'b1, 12'h7C0, 2'b00, 64'd0, 2'd3);
        step(1'b1, 12'h01F, 2'b01, 64'h1234, 2'd0);
        step(1'b1, 12'h01F, 2'b00, 64'd0, 2'd2);
        chk("t3_scr_u", csr_rdata_o, 64'h1234);

        // Test 4: multi-retire with inhibit for the middle cycle
        step(1'b1, 12'hB02, 2'b00, 64'd0, 2'd3);
        chk("t4_base", csr_rdata_o, 64'd0);
        instret_inc_i = 3'd7;
        step(1'b1, 12'h320, 2'b01, 64'h4, 2'd3);
        step(1'b1, 12'h320, 2'b01, 64'h0, 2'd3);
        idle();
        instret_inc_i = 3'd0;
        step(1'b1, 12'hB02, 2'b00, 64'd0, 2'd3);
        chk("t4_minstret", csr_rdata_o, 64'd14);
        step(1'b1, 12'h320, 2'b01, 64'h2, 2'd3);
        step(1'b1, 12'h320, 2'b00, 64'd0, 2'd3);
        chk("t4_inh_bit1", csr_rdata_o, 64'd0);

        // Test 5: hpm wrap, sticky overflow and clear on write
        step(1'b1, 12'hB03, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 2'd3);
        hpm_event_i = 4'b0001;
        idle();
        idle();
        hpm_event_i = 4'b0000;
        step(1'b1, 12'hB03, 2'b00, 64'd0, 2'd3);
        chk("t5_wrap", csr_rdata_o, 64'd0);
        chk("t5_irq", 64'(ovf_irq_o), 64'd1);
        step(1'b1, 12'hB03, 2'b01, 64'd5, 2'd3);
        step(1'b1, 12'hB03, 2'b00, 64'd0, 2'd3);
        chk("t5_val5", csr_rdata_o, 64'd5);
        chk("t5_irq_clr", 64'(ovf_irq_o), 64'd0);

        // Test 6: software write to a running mcycle, then reset during a write
        step(1'b1, 12'hB00, 2'b01, 64'd100, 2'd3);
        step(1'b1, 12'hB00, 2'b00, 64'd0, 2'd3);
        chk("t6_mcycle100", csr_rdata_o, 64'd100);
        step(1'b1, 12'hB00, 2'b00, 64'd0, 2'd3);
        chk("t6_mcycle101", csr_rdata_o, 64'd101);
        rst_n = 1'b0;
        step(1'b1, 12'h005, 2'b01, 64'h1234, 2'd3);
        chk("t6_rst_rvalid", 64'(csr_rvalid_o), 64'd0);
        chk("t6_rst_rdata", csr_rdata_o, 64'd0);
        rst_n = 1'b1;
        step(1'b1, 12'h005, 2'b00, 64'd0, 2'd3);
        chk("t6_after_rst", csr_rdata_o, 64'd0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
